// File: rtl/cmd_sender.sv
// Host-side command transmitter: sends a 16-bit command as two back-to-back UART frames, high byte first.
// Define CMD_SENDER_PARITY_EN to add an even-parity bit to each frame (8E1 instead of 8N1).
module cmd_sender #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_snt
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_TC = BW'(BAUD_DIV - 1);
`ifdef CMD_SENDER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [3:0] BIT_TC = 4'(FRAME_BITS - 1);
    // The start bit goes straight into TX, so the shifter holds only the remaining bits.
    localparam int SW = FRAME_BITS - 1;

    function automatic logic [SW-1:0] frame_tail(input logic [7:0] b);
`ifdef CMD_SENDER_PARITY_EN
        return {1'b1, ^b, b};
`else
        return {1'b1, b};
`endif
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TX_HI = 2'd1,
        TX_LO = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   baud_cnt;
    logic [3:0]      bit_cnt;
    logic [SW-1:0]   shifter;
    logic [7:0]      lo_q;
    logic            baud_tc;
    logic            frame_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        baud_tc    = (baud_cnt == BAUD_TC);
        frame_done = baud_tc && (bit_cnt == BIT_TC);
        case (state)
            IDLE:    if (snd_cmd)    state_nxt = TX_HI;
            TX_HI:   if (frame_done) state_nxt = TX_LO;
            TX_LO:   if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            TX       <= 1'b1;
            busy     <= 1'b0;
            cmd_snt  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            lo_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (snd_cmd) begin
                        lo_q     <= cmd[7:0];
                        shifter  <= frame_tail(cmd[15:8]);
                        TX       <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        cmd_snt  <= 1'b0;
                    end else begin
                        TX <= 1'b1;
                    end
                end
                TX_HI, TX_LO: begin
                    if (frame_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (state == TX_HI) begin
                            // Low byte's start bit follows the high byte's stop bit with no gap.
                            shifter <= frame_tail(lo_q);
                            TX      <= 1'b0;
                        end else begin
                            shifter <= '0;
                            TX      <= 1'b1;
                            busy    <= 1'b0;
                            cmd_snt <= 1'b1;
                        end
                    end else if (baud_tc) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        TX       <= shifter[0];
                        shifter  <= {1'b1, shifter[SW-1:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    TX <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sender.sv
// Self-checking bench for cmd_sender: every TX bit is compared against a line model derived from the frame rules.
`timescale 1ns/1ps
module tb_cmd_sender;

    localparam int B = 16;
`ifdef CMD_SENDER_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int T = 2 * F * B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        tx;
    logic        busy;
    logic        cmd_snt;

    int n_assert = 0;
    int n_fail   = 0;

    cmd_sender #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd     (cmd),
        .snd_cmd (snd_cmd),
        .TX      (tx),
        .busy    (busy),
        .cmd_snt (cmd_snt)
    );

    always #5 clk = ~clk;

    // Line level of bit number idx in the two-frame stream for command c.
    function automatic logic exp_bit(input logic [15:0] c, input int idx);
        logic [7:0] b;
        int j;
        b = (idx < F) ? c[15:8] : c[7:0];
        j = idx % F;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (j == F - 1) return 1'b1;
        return ^b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic idle_check(input int n, input logic exp_snt);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx", {31'd0, tx}, 32'd1);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_cmd_snt", {31'd0, cmd_snt}, {31'd0, exp_snt});
        end
    endtask

    // Must be called between a rising edge and the next one; the next rising edge is E0.
    task automatic send(input logic [15:0] c, input bit hold, input int rej_at, input int rst_at);
        snd_cmd = 1'b1;
        cmd     = c;
        for (int k = 0; k <= T; k++) begin
            @(negedge clk);
            if (k == T) begin
                check("done_tx", {31'd0, tx}, 32'd1);
                check("done_busy", {31'd0, busy}, 32'd0);
                check("done_cmd_snt", {31'd0, cmd_snt}, 32'd1);
            end else begin
                check("tx_bit", {31'd0, tx}, {31'd0, exp_bit(c, k / B)});
                check("busy_high", {31'd0, busy}, 32'd1);
                check("cmd_snt_low", {31'd0, cmd_snt}, 32'd0);
            end
            if (k == 0 && !hold) begin
                snd_cmd = 1'b0;
                cmd     = 16'($urandom);
            end
            if (rej_at > 0 && k == rej_at) begin
                snd_cmd = 1'b1;
                cmd     = 16'($urandom);
            end
            if (rej_at > 0 && k == rej_at + 1) snd_cmd = 1'b0;
            if (k == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_tx", {31'd0, tx}, 32'd1);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_cmd_snt", {31'd0, cmd_snt}, 32'd0);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [15:0] c;
        rst_n   = 1'b0;
        snd_cmd = 1'b0;
        cmd     = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_cmd_snt", {31'd0, cmd_snt}, 32'd0);
        rst_n = 1'b1;
        idle_check(3, 1'b0);

        // basic send, cmd_snt stays high afterwards
        send(16'h0039, 1'b0, -1, -1);
        idle_check(5, 1'b1);

        // a request arriving mid-transfer must be ignored
        send(16'hA55A, 1'b0, 100, -1);
        idle_check(3, 1'b1);

        // reset mid-frame, then a clean send
        send(16'hBEEF, 1'b0, -1, 150);
        idle_check(2, 1'b0);
        send(16'h1234, 1'b0, -1, -1);
        idle_check(2, 1'b1);

        // held request: back-to-back commands, cmd_snt a single-cycle pulse in between
        send(16'h8001, 1'b1, -1, -1);
        send(16'h8001, 1'b1, -1, -1);
        snd_cmd = 1'b0;
        idle_check(3, 1'b1);

        send(16'h0301, 1'b0, -1, -1);
        idle_check(2, 1'b1);

        for (int i = 0; i < 6; i++) begin
            c = 16'($urandom);
            send(c, 1'b0, (i % 2 == 0) ? int'($urandom_range(1, T - 10)) : -1, -1);
            idle_check(int'($urandom_range(0, 5)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
